// File: rtl/apb_master_arb_swc_if.sv
// Requester-side and APB-side signal bundle for apb_master_arb_swc.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_master_arb_swc_if #(
   parameter int NUM_REQ = 2
) ();
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_write;
   logic [NUM_REQ*32-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_wdata;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic [31:0]           paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [31:0]           pwdata;
   logic                  pready;
   logic [31:0]           prdata;
   logic                  pslverr;

   modport master (
      input  req, req_write, req_addr, req_wdata, pready, prdata, pslverr,
      output rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output req, req_write, req_addr, req_wdata, pready, prdata, pslverr,
      input  rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
   );
endinterface

// File: rtl/apb_master_arb_swc.sv
// Round-robin arbiter + APB master sequencer sharing one APB bus among NUM_REQ requesters.
// Optional ACCESS-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb_swc #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 64
) (
   input logic                 pclk,
   input logic                 prstn,
   apb_master_arb_swc_if.master bus
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("apb_master_arb_swc: NUM_REQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t        state;
   logic [GW-1:0] grant;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] win;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt;
`endif

   // First set request bit after last_grant, wrapping modulo NUM_REQ.
   always_comb begin
      logic found;
      int unsigned idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant) + k) % NUM_REQ;
         if (!found && bus.req[idx]) begin
            win   = GW'(idx);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state         <= IDLE;
         grant         <= '0;
         last_grant    <= GW'(NUM_REQ - 1);
         bus.psel      <= 1'b0;
         bus.penable   <= 1'b0;
         bus.pwrite    <= 1'b0;
         bus.paddr     <= '0;
         bus.pwdata    <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         bus.rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  grant      <= win;
                  bus.paddr  <= bus.req_addr[32*int'(win) +: 32];
                  bus.pwdata <= bus.req_wdata[32*int'(win) +: 32];
                  bus.pwrite <= bus.req_write[win];
                  bus.psel   <= 1'b1;
                  state      <= SETUP;
`ifdef APB_ARB_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
               end
            end
            SETUP: begin
               bus.penable <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (bus.pready) begin
                  bus.psel             <= 1'b0;
                  bus.penable          <= 1'b0;
                  bus.rsp_rdata        <= bus.pwrite ? '0 : bus.prdata;
                  bus.rsp_err          <= bus.pslverr;
                  bus.rsp_valid[grant] <= 1'b1;
                  state                <= RESP;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                  bus.psel             <= 1'b0;
                  bus.penable          <= 1'b0;
                  bus.rsp_rdata        <= '0;
                  bus.rsp_err          <= 1'b1;
                  bus.rsp_valid[grant] <= 1'b1;
                  state                <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               last_grant <= grant;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_arb_swc.sv
// Self-checking bench for apb_master_arb_swc: directed scenarios plus randomized
// traffic, all checked against a transaction-level model of the arbiter.
module tb_apb_master_arb_swc;
   localparam int NR = 4;
   localparam int TO = 8;
`ifdef APB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic pclk  = 1'b0;
   logic prstn = 1'b1;
   always #5 pclk = ~pclk;

   apb_master_arb_swc_if #(.NUM_REQ(NR)) bus ();
   apb_master_arb_swc #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (.pclk(pclk), .prstn(prstn), .bus(bus));

   typedef enum {P_IDLE, P_SETUP, P_ACCESS, P_RESP} phase_e;

   int n_err    = 0;
   int n_checks = 0;

   logic [NR-1:0] pend, reissue;
   logic [31:0]   a [NR];
   logic [31:0]   d [NR];
   logic          w [NR];

   phase_e ph;
   int     cur, last, acc_n, last_acc;
   logic [31:0] exp_a, exp_d, exp_rd;
   logic        exp_w, exp_err;
   int          served_q[$];

   bit          gen_en, rand_slave, hang;
   int          s_waits;
   logic [31:0] s_rdata;
   logic        s_err;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] p, input int lst);
      for (int k = 1; k <= NR; k++)
         if (p[(lst + k) % NR]) return (lst + k) % NR;
      return 0;
   endfunction

   task automatic new_req(input int i, input logic [31:0] ad, input logic wr, input logic [31:0] wd);
      pend[i] = 1'b1;
      a[i]    = ad;
      w[i]    = wr;
      d[i]    = wd;
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus.req[i]                = pend[i];
         bus.req_write[i]          = w[i];
         bus.req_addr[32*i +: 32]  = a[i];
         bus.req_wdata[32*i +: 32] = d[i];
      end
   endtask

   // One clock: advance the transfer model, compare all outputs, then drive new inputs.
   task automatic cycle();
      @(negedge pclk);
      case (ph)
         P_IDLE: if (pend != '0) begin
            cur   = rr_pick(pend, last);
            ph    = P_SETUP;
            exp_a = a[cur];
            exp_w = w[cur];
            exp_d = d[cur];
         end
         P_SETUP: begin
            ph    = P_ACCESS;
            acc_n = 1;
         end
         P_ACCESS: begin
            if (bus.pready) begin
               ph      = P_RESP;
               exp_rd  = exp_w ? 32'd0 : bus.prdata;
               exp_err = bus.pslverr;
            end else if (TO_EN && acc_n == TO) begin
               ph      = P_RESP;
               exp_rd  = 32'd0;
               exp_err = 1'b1;
            end else begin
               acc_n++;
            end
         end
         P_RESP: begin
            ph   = P_IDLE;
            last = cur;
         end
      endcase

      check_eq("psel", 32'(bus.psel), 32'(ph == P_SETUP || ph == P_ACCESS));
      check_eq("penable", 32'(bus.penable), 32'(ph == P_ACCESS));
      check_eq("rsp_valid", 32'(bus.rsp_valid), (ph == P_RESP) ? 32'(1 << cur) : 32'd0);
      check_eq("paddr", bus.paddr, exp_a);
      check_eq("pwrite", 32'(bus.pwrite), 32'(exp_w));
      check_eq("pwdata", bus.pwdata, exp_d);
      check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));

      if (ph == P_RESP) begin
         served_q.push_back(cur);
         last_acc = acc_n;
         if (reissue[cur]) new_req(cur, $urandom, 1'($urandom_range(0, 1)), $urandom);
         else pend[cur] = 1'b0;
      end
      if (gen_en) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 3) == 0) new_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
            end else if (!(ph != P_IDLE && i == cur) && $urandom_range(0, 15) == 0) begin
               pend[i] = 1'b0;
            end
         end
      end

      if (hang) begin
         bus.pready = 1'b0;
      end else if (rand_slave) begin
         bus.pready  = ($urandom_range(0, 2) != 0);
         bus.prdata  = $urandom;
         bus.pslverr = ($urandom_range(0, 3) == 0);
      end else begin
         bus.pready  = (ph == P_ACCESS && acc_n > s_waits);
         bus.prdata  = s_rdata;
         bus.pslverr = s_err;
      end
      drive();
   endtask

   task automatic reset_dut(input int dly);
      #dly;
      prstn = 1'b0;
      #1;
      check_eq("rst_psel", 32'(bus.psel), 32'd0);
      check_eq("rst_penable", 32'(bus.penable), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_eq("rst_paddr", bus.paddr, 32'd0);
      check_eq("rst_pwrite", 32'(bus.pwrite), 32'd0);
      check_eq("rst_pwdata", bus.pwdata, 32'd0);
      ph      = P_IDLE;
      last    = NR - 1;
      acc_n   = 0;
      exp_a   = '0;
      exp_d   = '0;
      exp_w   = 1'b0;
      exp_rd  = '0;
      exp_err = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      prstn = 1'b1;
   endtask

   task automatic run_until(input int target, input int budget);
      int b = 0;
      while (served_q.size() < target && b < budget) begin
         cycle();
         b++;
      end
      check_eq("served_in_budget", 32'(served_q.size() >= target), 32'd1);
   endtask

   task automatic drain(input int budget);
      int b = 0;
      while ((pend != '0 || ph != P_IDLE) && b < budget) begin
         cycle();
         b++;
      end
      check_eq("drained_in_budget", 32'(pend == '0 && ph == P_IDLE), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int b;
      pend = '0;
      reissue = '0;
      for (int i = 0; i < NR; i++) begin
         a[i] = '0;
         d[i] = '0;
         w[i] = 1'b0;
      end
      gen_en = 0; rand_slave = 0; hang = 0;
      s_waits = 0; s_rdata = '0; s_err = 1'b0;
      bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
      drive();
      reset_dut(2);

      // Single read with one wait state
      s_waits = 1; s_rdata = 32'h0000_00A5; s_err = 1'b0;
      new_req(0, 32'h0010_0104, 1'b0, 32'd0);
      drive();
      run_until(1, 20);
      check_eq("rd_grant", 32'(served_q[0]), 32'd0);
      check_eq("rd_access_cycles", 32'(last_acc), 32'd2);
      check_eq("rd_rdata", bus.rsp_rdata, 32'h0000_00A5);

      // Write to undecoded address, slave error
      s_waits = 0; s_err = 1'b1; s_rdata = 32'hFFFF_FFFF;
      new_req(1, 32'h0010_0200, 1'b1, 32'h0000_1234);
      drive();
      run_until(2, 20);
      check_eq("wr_grant", 32'(served_q[1]), 32'd1);
      check_eq("wr_err", 32'(bus.rsp_err), 32'd1);
      check_eq("wr_rdata", bus.rsp_rdata, 32'd0);

      // Continuous contention between 0 and 1
      s_err = 1'b0; s_rdata = 32'h5A5A_0001;
      reissue = 4'b0011;
      new_req(0, $urandom, 1'b0, $urandom);
      new_req(1, $urandom, 1'b1, $urandom);
      drive();
      base = served_q.size();
      run_until(base + 4, 60);
      reissue = '0;
      drain(60);
      for (int k = 0; k < 4; k++) check_eq("contention_order", 32'(served_q[base + k]), 32'(k % 2));

      // Fairness right after reset: 1 before 3
      reset_dut(3);
      new_req(3, 32'h0010_0030, 1'b0, 32'd0);
      new_req(1, 32'h0010_0010, 1'b1, 32'h0000_0011);
      drive();
      base = served_q.size();
      run_until(base + 2, 30);
      check_eq("fair_first", 32'(served_q[base]), 32'd1);
      check_eq("fair_second", 32'(served_q[base + 1]), 32'd3);
      drain(30);

      // Async reset during ACCESS
      hang = 1;
      new_req(2, 32'h0010_0300, 1'b0, 32'd0);
      drive();
      b = 0;
      while (!(ph == P_ACCESS && acc_n == 2) && b < 20) begin
         cycle();
         b++;
      end
      check_eq("reached_access", 32'(ph == P_ACCESS), 32'd1);
      reset_dut(3);
      hang = 0; s_waits = 0; s_rdata = 32'h0000_0077;
      base = served_q.size();
      run_until(base + 1, 20);
      check_eq("post_reset_grant", 32'(served_q[base]), 32'd2);

      // Slave that never answers
      hang = 1;
      new_req(0, 32'h0010_0400, 1'b0, 32'd0);
      drive();
      base = served_q.size();
`ifdef APB_ARB_TIMEOUT_EN
      run_until(base + 1, 30);
      check_eq("to_access_cycles", 32'(last_acc), 32'(TO));
      check_eq("to_err", 32'(bus.rsp_err), 32'd1);
      check_eq("to_rdata", bus.rsp_rdata, 32'd0);
      hang = 0;
`else
      repeat (100) cycle();
      check_eq("hang_psel", 32'(bus.psel), 32'd1);
      check_eq("hang_not_served", 32'(served_q.size()), 32'(base));
      pend = '0;
      drive();
      hang = 0;
      reset_dut(3);
`endif

      // Randomized traffic
      gen_en = 1; rand_slave = 1;
      repeat (600) cycle();
      gen_en = 0;
      drain(400);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
